m2_tx_sched: RTL

M2_TX_SCHED -- requirements
Module: m2_tx_sched

---
 rtl/m2_tx_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/m2_tx_sched.sv
//==============================================================================
// Module   : m2_tx_sched
// Purpose  : Two-source byte scheduler feeding the M2 encoder with command
//            priority bounded by a picture burst limit and a post-read guard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module m2_tx_sched #(
   parameter logic [7:0] PIC_BURST = 8'd16,
   parameter logic [3:0] GUARD     = 4'd4
) (
   input  logic       clock_41p766k,
   input  logic       Rst,
   input  logic       cmd_empty,
   input  logic [7:0] cmd_data,
   output logic       cmd_rd_en,
   input  logic       pic_empty,
   input  logic [7:0] pic_data,
   output logic       pic_rd_en,
   input  logic       enc_rd_en,
   output logic       enc_empty,
   output logic [7:0] enc_data,
   output logic       enc_src,
   output logic       rd_err
);

   localparam logic [7:0] c_BURST_SAT = 8'hFF;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARB        = 3'd1,
      FETCH      = 3'd2,
      CAPTURE    = 3'd3,
      HOLD       = 3'd4,
      GUARD_WAIT = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic       r_sel_src;
   logic [7:0] r_burst_cnt;
   logic [3:0] r_guard_cnt;
   logic       w_grant_cmd;
   logic       w_grant_pic;
   logic       w_guard_done;

   // Command wins when the picture burst is exhausted, has not started, or pictures are absent.
   assign w_grant_cmd  = (r_state == ARB) && !cmd_empty &&
                         ((r_burst_cnt >= PIC_BURST) || (r_burst_cnt == 8'd0) || pic_empty);
   assign w_grant_pic  = (r_state == ARB) && !w_grant_cmd && !pic_empty;
   assign w_guard_done = ({1'b0, r_guard_cnt} + 5'd1) >= {1'b0, GUARD};

   always_ff @(posedge clock_41p766k or negedge Rst) begin
      if (!Rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      cmd_rd_en    = 1'b0;
      pic_rd_en    = 1'b0;
      case (r_state)
         IDLE: begin
            if (!cmd_empty || !pic_empty) begin
               w_next_state = ARB;
            end
         end
         ARB: begin
            if (w_grant_cmd || w_grant_pic) begin
               w_next_state = FETCH;
            end else begin
               w_next_state = IDLE;
            end
         end
         FETCH: begin
            cmd_rd_en    = r_sel_src;
            pic_rd_en    = !r_sel_src;
            w_next_state = CAPTURE;
         end
         CAPTURE: begin
            w_next_state = HOLD;
         end
         HOLD: begin
            if (enc_rd_en) begin
               w_next_state = GUARD_WAIT;
            end
         end
         GUARD_WAIT: begin
            if (w_guard_done) begin
               w_next_state = ARB;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_41p766k or negedge Rst) begin
      if (!Rst) begin
         r_sel_src   <= 1'b0;
         r_burst_cnt <= 8'd0;
         r_guard_cnt <= 4'd0;
         enc_empty   <= 1'b1;
         enc_data    <= 8'h00;
         enc_src     <= 1'b0;
         rd_err      <= 1'b0;
      end else begin
         if (r_state == ARB) begin
            if (w_grant_cmd) begin
               r_sel_src   <= 1'b1;
               r_burst_cnt <= 8'd0;
            end else if (w_grant_pic) begin
               r_sel_src   <= 1'b0;
               r_burst_cnt <= (r_burst_cnt == c_BURST_SAT) ? c_BURST_SAT : r_burst_cnt + 8'd1;
            end
            if (pic_empty) begin
               r_burst_cnt <= 8'd0;
            end
         end

         if (r_state == CAPTURE) begin
            enc_data  <= r_sel_src ? cmd_data : pic_data;
            enc_src   <= r_sel_src;
            enc_empty <= 1'b0;
         end

         if ((r_state == HOLD) && enc_rd_en) begin
            enc_empty   <= 1'b1;
            r_guard_cnt <= 4'd0;
         end else if (r_state == GUARD_WAIT) begin
            r_guard_cnt <= r_guard_cnt + 4'd1;
         end

         // A read outside HOLD (including the CAPTURE cycle) is a protocol error.
         if (enc_rd_en && (r_state != HOLD)) begin
            rd_err <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
